seq_neuron: RTL and testbench

- Sequential, parametrised neuron for the FNN datapath.
- Streams N_INPUTS sign-magnitude activation/weight pairs through one multiplier, one pair per accepted beat, into a two's-complement accumulator.
- After the last beat it adds the 127-scaled bias, truncates by SHIFT, applies the selected activation and saturates to a sign-magnitude output.
- It replaces the fully-parallel 62-input neuron wherever area matters more than latency.

---
 rtl/fnn_pkg.sv | 53 +++++
 rtl/seq_neuron_sm_mul.sv | 22 ++
 rtl/seq_neuron.sv | 108 ++++++++++
 tb/tb_seq_neuron.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fnn_pkg.sv
// Shared types and helpers for the FNN datapath.
//   nrn_state_t : sequential neuron FSM states
//   clog2       : ceiling log2, usable in parameter expressions
//   sm_to_tc    : sign-magnitude to two's complement
//   tc_to_sm_sat: two's complement to sign-magnitude with shift and saturation
package fnn_pkg;

  localparam int unsigned ACT_RELU  = 0;
  localparam int unsigned ACT_IDENT = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_FINISH = 2'd2,
    ST_OUT    = 2'd3
  } nrn_state_t;

  // Smallest r with 2**r >= v; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = 32'(i + 1);
    end
    return r;
  endfunction

  // Zero magnitude yields 0 whatever the sign, so -0 is harmless.
  function automatic logic signed [63:0] sm_to_tc(input logic sign, input logic [62:0] mag);
    return sign ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  function automatic logic [63:0] sat_mag(input logic [63:0] mag, input int unsigned mag_w);
    logic [63:0] max_mag;
    max_mag = (64'(1) << mag_w) - 64'(1);
    return (mag > max_mag) ? max_mag : mag;
  endfunction

  // Truncates |v| >> shift toward zero, saturates, and never returns -0.
  // Sign lands in bit mag_w, magnitude in the bits below it.
  function automatic logic [63:0] tc_to_sm_sat(input logic signed [63:0] v,
                                               input int unsigned mag_w,
                                               input int unsigned shift);
    logic        neg;
    logic [63:0] abs_v;
    logic [63:0] m;
    neg   = v[63];
    abs_v = neg ? 64'(-v) : 64'(v);
    m     = sat_mag(abs_v >> shift, mag_w);
    return (64'(neg && (m != 64'(0))) << mag_w) | m;
  endfunction

endpackage

// File: rtl/seq_neuron_sm_mul.sv
// Combinational sign-magnitude multiplier.
//   a, b   : MAG_W+1 sign-magnitude operands (MSB = sign)
//   prod_c : 2*MAG_W+1 two's-complement product
module sm_mul
  import fnn_pkg::*;
#(
  parameter int unsigned MAG_W = 7
) (
  input  logic [MAG_W:0]          a,
  input  logic [MAG_W:0]          b,
  output logic signed [2*MAG_W:0] prod_c
);

  localparam int unsigned MW2    = 2 * MAG_W;
  localparam int unsigned PROD_W = 2 * MAG_W + 1;

  logic [MW2-1:0] mag;

  assign mag    = MW2'(a[MAG_W-1:0]) * MW2'(b[MAG_W-1:0]);
  assign prod_c = PROD_W'(sm_to_tc(a[MAG_W] ^ b[MAG_W], 63'(mag)));

endmodule

// File: rtl/seq_neuron.sv
// Sequential neuron: one multiply-accumulate per accepted beat, then bias,
// shift, activation and sign-magnitude saturation.
//   start/bias           : begin inference, bias latched on accepted start
//   in_valid/in_ready    : activation/weight beat handshake (ready only in ACCUM)
//   in_act/in_weight     : sign-magnitude operands
//   out_valid/out_ready  : result handshake, out_data held until accepted
//   busy                 : high whenever not IDLE
module seq_neuron
  import fnn_pkg::*;
#(
  parameter int unsigned N_INPUTS = 62,
  parameter int unsigned MAG_W    = 7,
  parameter int unsigned SHIFT    = 8,
  parameter int unsigned ACT_MODE = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [MAG_W:0] bias,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [MAG_W:0] in_act,
  input  logic [MAG_W:0] in_weight,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [MAG_W:0] out_data,
  output logic           busy
);

  localparam int unsigned OP_W    = MAG_W + 1;
  localparam int unsigned ACC_W   = 2 * MAG_W + clog2(N_INPUTS) + 3;
  localparam int unsigned CNT_W   = clog2(N_INPUTS + 1);
  localparam int unsigned MAX_MAG = (1 << MAG_W) - 1;

  nrn_state_t               state;
  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         cnt;
  logic [MAG_W:0]           bias_r;
  logic signed [2*MAG_W:0]  prod_c;
  logic signed [ACC_W-1:0]  bias_tc_c;
  logic signed [ACC_W-1:0]  sum_c;
  logic [MAG_W:0]           res_c;

  sm_mul #(.MAG_W(MAG_W)) u_mul (
    .a      (in_act),
    .b      (in_weight),
    .prod_c (prod_c)
  );

  // Post-processing of the finished accumulation; only sampled in FINISH.
  always_comb begin
    bias_tc_c = ACC_W'(sm_to_tc(bias_r[MAG_W], 63'(bias_r[MAG_W-1:0]) * 63'(MAX_MAG)));
    sum_c     = acc + bias_tc_c;
    res_c     = OP_W'(tc_to_sm_sat(64'(sum_c), MAG_W, SHIFT));
    if (ACT_MODE == ACT_RELU && sum_c[ACC_W-1]) res_c = '0;
  end

  // FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      cnt       <= '0;
      bias_r    <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            bias_r   <= bias;
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (in_valid) begin
            acc <= acc + ACC_W'(prod_c);
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(N_INPUTS - 1)) begin
              in_ready <= 1'b0;
              state    <= ST_FINISH;
            end
          end
        end
        ST_FINISH: begin
          out_data  <= res_c;
          out_valid <= 1'b1;
          state     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_neuron.sv
// Directed bench for seq_neuron. Group 0 drives an N_INPUTS=4 pair
// (ReLU + identity), group 1 an N_INPUTS=62 pair; both instances of a group
// share stimulus so each vector checks both activation modes.
module tb_seq_neuron;

  logic clk;
  logic rst_n;

  logic       start     [2];
  logic [7:0] bias      [2];
  logic       in_valid  [2];
  logic [7:0] in_act    [2];
  logic [7:0] in_weight [2];
  logic       out_ready [2];

  logic       in_ready  [4];
  logic       out_valid [4];
  logic [7:0] out_data  [4];
  logic       busy      [4];

  int total;
  int bad;

  typedef struct packed {
    logic            g;
    logic [7:0]      bias;
    logic [3:0][7:0] a;
    logic [3:0][7:0] w;
    logic [7:0]      er;
    logic [7:0]      ei;
  } vec_t;

  vec_t vecs [9];

  seq_neuron #(.N_INPUTS(4), .ACT_MODE(0)) u_r4 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .bias(bias[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_act(in_act[0]), .in_weight(in_weight[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0]));
  seq_neuron #(.N_INPUTS(4), .ACT_MODE(1)) u_i4 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .bias(bias[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[1]), .in_act(in_act[0]), .in_weight(in_weight[0]),
    .out_valid(out_valid[1]), .out_ready(out_ready[0]), .out_data(out_data[1]), .busy(busy[1]));
  seq_neuron #(.N_INPUTS(62), .ACT_MODE(0)) u_r62 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .bias(bias[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[2]), .in_act(in_act[1]), .in_weight(in_weight[1]),
    .out_valid(out_valid[2]), .out_ready(out_ready[1]), .out_data(out_data[2]), .busy(busy[2]));
  seq_neuron #(.N_INPUTS(62), .ACT_MODE(1)) u_i62 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .bias(bias[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[3]), .in_act(in_act[1]), .in_weight(in_weight[1]),
    .out_valid(out_valid[3]), .out_ready(out_ready[1]), .out_data(out_data[3]), .busy(busy[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic g, input logic [7:0] b,
                              input logic [7:0] a0, input logic [7:0] a1,
                              input logic [7:0] a2, input logic [7:0] a3,
                              input logic [7:0] w0, input logic [7:0] w1,
                              input logic [7:0] w2, input logic [7:0] w3,
                              input logic [7:0] er, input logic [7:0] ei);
    vec_t v;
    v.g = g; v.bias = b;
    v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.er = er; v.ei = ei;
    return v;
  endfunction

  // Feed one inference (beats cycle through a[]/w[]) and check both modes.
  task automatic run_vec(input int idx, input vec_t v, input bit gaps, input int hold);
    int g;
    int n;
    int r;
    int k;
    bit ok;
    logic [7:0] dr;
    logic [7:0] di;
    g = int'(v.g);
    n = (g == 1) ? 62 : 4;
    r = 2 * g;
    @(negedge clk);
    start[g] = 1'b1;
    bias[g]  = v.bias;
    @(negedge clk);
    start[g] = 1'b0;
    bias[g]  = 8'h00;
    for (int b = 0; b < n; b++) begin
      if (gaps) begin
        k = int'($urandom_range(0, 2));
        for (int j = 0; j < k; j++) begin
          in_valid[g] = 1'b0;
          in_act[g]   = 8'h7F;
          in_weight[g] = 8'h7F;
          @(negedge clk);
        end
      end
      if (b == 0 || b == n - 1)
        chk($sformatf("v%0d_in_ready_accum", idx), 32'({in_ready[r], in_ready[r+1]}), 32'h3);
      in_valid[g]  = 1'b1;
      in_act[g]    = v.a[b % 4];
      in_weight[g] = v.w[b % 4];
      @(negedge clk);
    end
    in_valid[g] = 1'b0;
    // One cycle after the last beat: FINISH, nothing visible yet.
    chk($sformatf("v%0d_finish", idx),
        32'({out_valid[r], out_valid[r+1], in_ready[r], in_ready[r+1]}), 32'h0);
    @(negedge clk);
    chk($sformatf("v%0d_latency", idx), 32'({out_valid[r], out_valid[r+1]}), 32'h3);
    for (int t = 0; t < 20 && !(out_valid[r] && out_valid[r+1]); t++) @(negedge clk);
    chk($sformatf("v%0d_relu", idx), 32'(out_data[r]), 32'(v.er));
    chk($sformatf("v%0d_ident", idx), 32'(out_data[r+1]), 32'(v.ei));
    dr = out_data[r];
    di = out_data[r+1];
    if (hold > 0) begin
      ok = 1'b1;
      for (int h = 0; h < hold; h++) begin
        out_ready[g] = 1'b0;
        start[g]     = (h == 2);
        @(negedge clk);
        if (!(out_valid[r] && out_valid[r+1])) ok = 1'b0;
        if (out_data[r] !== dr || out_data[r+1] !== di) ok = 1'b0;
        if (in_ready[r] || in_ready[r+1]) ok = 1'b0;
        if (!(busy[r] && busy[r+1])) ok = 1'b0;
      end
      start[g] = 1'b0;
      chk($sformatf("v%0d_hold_stable", idx), 32'(ok), 32'h1);
    end
    out_ready[g] = 1'b1;
    start[g]     = 1'b1;
    @(negedge clk);
    out_ready[g] = 1'b0;
    start[g]     = 1'b0;
    chk($sformatf("v%0d_released", idx),
        32'({out_valid[r], out_valid[r+1], busy[r], busy[r+1]}), 32'h0);
    chk($sformatf("v%0d_data_kept", idx), 32'({out_data[r], out_data[r+1]}), 32'({dr, di}));
    @(negedge clk);
    chk($sformatf("v%0d_start_ignored", idx), 32'({busy[r], busy[r+1]}), 32'h0);
  endtask

  initial begin
    bit ok;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      start[g] = 1'b0; bias[g] = 8'h00; in_valid[g] = 1'b0;
      in_act[g] = 8'h00; in_weight[g] = 8'h00; out_ready[g] = 1'b0;
    end

    // acts {+100,+93,-103,-127}, weights {-5,+4,-3,+2}: acc -73 (N=4), -1223 (N=62)
    vecs[0] = mk(1'b0, 8'h64, 8'h64, 8'h5D, 8'hE7, 8'hFF, 8'h85, 8'h04, 8'h83, 8'h02, 8'h31, 8'h31);
    vecs[1] = mk(1'b0, 8'hE4, 8'h64, 8'h5D, 8'hE7, 8'hFF, 8'h85, 8'h04, 8'h83, 8'h02, 8'h00, 8'hB1);
    // -255 >> 8 truncates to 0: no -0; -0 operands contribute nothing
    vecs[2] = mk(1'b0, 8'h00, 8'h33, 8'h80, 8'h80, 8'h00, 8'h85, 8'h80, 8'h05, 8'h80, 8'h00, 8'h00);
    // 4*16129 = 64516 -> 252, saturates
    vecs[3] = mk(1'b0, 8'h00, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F);
    // -256 -> magnitude exactly 1
    vecs[4] = mk(1'b0, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h90, 8'h00, 8'h00, 8'h00, 8'h00, 8'h81);
    // 62 * 127*127 + 16129 saturates positive; with -127 weights saturates negative
    vecs[5] = mk(1'b1, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F);
    vecs[6] = mk(1'b1, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF);
    // -1223 + 12700 = 11477 -> 44 ; -1223 - 12700 = -13923 -> -54
    vecs[7] = mk(1'b1, 8'h64, 8'h64, 8'h5D, 8'hE7, 8'hFF, 8'h85, 8'h04, 8'h83, 8'h02, 8'h2C, 8'h2C);
    vecs[8] = mk(1'b1, 8'hE4, 8'h64, 8'h5D, 8'hE7, 8'hFF, 8'h85, 8'h04, 8'h83, 8'h02, 8'h00, 8'hB6);

    repeat (3) @(negedge clk);
    ok = 1'b1;
    for (int i = 0; i < 4; i++)
      if (in_ready[i] !== 1'b0 || out_valid[i] !== 1'b0 || busy[i] !== 1'b0 || out_data[i] !== 8'h00)
        ok = 1'b0;
    chk("reset_state", 32'(ok), 32'h1);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i], 1'b0, 0);

    // Bubbles on the input side plus downstream backpressure.
    run_vec(10, vecs[0], 1'b1, 10);
    run_vec(17, vecs[7], 1'b1, 10);

    // Abort after 30 of 62 beats.
    @(negedge clk);
    start[1] = 1'b1;
    bias[1]  = 8'h7F;
    @(negedge clk);
    start[1] = 1'b0;
    for (int b = 0; b < 30; b++) begin
      in_valid[1]  = 1'b1;
      in_act[1]    = 8'h7F;
      in_weight[1] = 8'h7F;
      @(negedge clk);
    end
    chk("abort_busy_before", 32'({busy[2], busy[3]}), 32'h3);
    in_valid[1] = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 4; i++)
      if (in_ready[i] !== 1'b0 || out_valid[i] !== 1'b0 || busy[i] !== 1'b0 || out_data[i] !== 8'h00)
        ok = 1'b0;
    chk("abort_reset_zero", 32'(ok), 32'h1);
    repeat (5) @(negedge clk);
    chk("abort_no_output", 32'({out_valid[2], out_valid[3]}), 32'h0);
    run_vec(20, vecs[8], 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
